// File: rtl/issue_unit.sv
// issue_unit: fetch-side instruction queue with in-order single-issue dispatch to ROB plus RS/LSB.
// The head entry is decoded combinationally; illegal opcodes are popped without dispatch.
module issue_decoder #(
    parameter int OP_W = 6
) (
    input  logic [31:0]     inst,
    output logic            legal,
    output logic            is_ls,
    output logic            is_store,
    output logic            is_branch,
    output logic [OP_W-1:0] op,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     imm
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       lui, auipc, jal, jalr, br, ld, st, opi, opr, alt;
    logic [5:0] code;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign lui   = opc == 7'b0110111;
    assign auipc = opc == 7'b0010111;
    assign jal   = opc == 7'b1101111;
    assign jalr  = opc == 7'b1100111;
    assign br    = opc == 7'b1100011;
    assign ld    = opc == 7'b0000011;
    assign st    = opc == 7'b0100011;
    assign opi   = opc == 7'b0010011;
    assign opr   = opc == 7'b0110011;
    assign legal     = lui | auipc | jal | jalr | br | ld | st | opi | opr;
    assign is_ls     = ld | st;
    assign is_store  = st;
    assign is_branch = br | jal | jalr;
    // bit 30 selects SUB/SRA/SRAI variants
    assign alt = inst[30] & (opr | (opi & (f3 == 3'b101)));
    always_comb begin
        code = lui   ? 6'd1 :
               auipc ? 6'd2 :
               jal   ? 6'd3 :
               jalr  ? 6'd4 :
               br    ? {3'b001, f3} :
               ld    ? {3'b010, f3} :
               st    ? {3'b011, f3} :
               opi   ? {2'b10, alt, f3} :
               opr   ? {2'b11, alt, f3} : 6'd0;
        imm  = (lui | auipc) ? {inst[31:12], 12'b0} :
               jal ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
               br  ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
               st  ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
               opr ? 32'd0 : {{20{inst[31]}}, inst[31:20]};
    end
    assign op  = OP_W'(code);
    assign rd  = (br | st) ? 5'd0 : inst[11:7];
    assign rs1 = (lui | auipc | jal) ? 5'd0 : inst[19:15];
    assign rs2 = (br | st | opr) ? inst[24:20] : 5'd0;
endmodule

module issue_unit #(
    parameter int DEPTH = 16,
    parameter int OP_W  = 6
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [31:0]     if_pc,
    input  logic            if_pred_taken,
    output logic            iq_full,
    input  logic            rob_full,
    input  logic            rs_full,
    input  logic            lsb_full,
    output logic            dsp_valid,
    output logic            dsp_to_lsb,
    output logic            dsp_is_store,
    output logic            dsp_is_branch,
    output logic [OP_W-1:0] dsp_op,
    output logic [4:0]      dsp_rd,
    output logic [4:0]      dsp_rs1,
    output logic [4:0]      dsp_rs2,
    output logic [31:0]     dsp_imm,
    output logic [31:0]     dsp_pc,
    output logic            dsp_pred_taken
);
    localparam int AW = $clog2(DEPTH);
    logic [64:0]     mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [AW:0]     count;
    logic [64:0]     hd;
    logic            legal, is_ls, is_store, is_branch;
    logic [OP_W-1:0] op;
    logic [4:0]      rd, rs1, rs2;
    logic [31:0]     imm;
    logic            empty, tgt_full, fire, pop, push;
    assign hd = mem[head];
    issue_decoder #(.OP_W(OP_W)) u_dec (
        .inst(hd[31:0]), .legal(legal), .is_ls(is_ls), .is_store(is_store),
        .is_branch(is_branch), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm)
    );
    assign iq_full  = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign tgt_full = is_ls ? lsb_full : rs_full;
    assign fire     = !empty && legal && !rob_full && !tgt_full && !flush_in;
    // illegal words leave the queue regardless of back-pressure
    assign pop      = !empty && !flush_in && (fire || !legal);
    assign push     = if_valid && !iq_full && !flush_in;
    always_ff @(posedge clk_in)
        if (rdy_in && push) mem[tail] <= {if_pred_taken, if_pc, if_inst};
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            dsp_valid      <= 1'b0;
            dsp_to_lsb     <= 1'b0;
            dsp_is_store   <= 1'b0;
            dsp_is_branch  <= 1'b0;
            dsp_op         <= '0;
            dsp_rd         <= '0;
            dsp_rs1        <= '0;
            dsp_rs2        <= '0;
            dsp_imm        <= '0;
            dsp_pc         <= '0;
            dsp_pred_taken <= 1'b0;
        end else if (rdy_in) begin
            head      <= flush_in ? '0 : head + AW'(pop);
            tail      <= flush_in ? '0 : tail + AW'(push);
            count     <= flush_in ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
            dsp_valid <= fire;
            if (fire) begin
                dsp_to_lsb     <= is_ls;
                dsp_is_store   <= is_store;
                dsp_is_branch  <= is_branch;
                dsp_op         <= op;
                dsp_rd         <= rd;
                dsp_rs1        <= rs1;
                dsp_rs2        <= rs2;
                dsp_imm        <= imm;
                dsp_pc         <= hd[63:32];
                dsp_pred_taken <= hd[64];
            end
        end
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed and randomized checks of issue_unit against a queue-based reference model.
module tb_issue_unit;
    localparam int DEPTH = 16;
    typedef struct packed {
        logic lsb; logic st; logic br; logic [5:0] op;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
        logic [31:0] imm; logic [31:0] pc; logic pred;
    } fld_t;
    logic clk = 0, rst = 1, rdy = 1, flush = 0, if_valid = 0, if_pred = 0;
    logic rob_full = 0, rs_full = 0, lsb_full = 0;
    logic [31:0] if_inst = 0, if_pc = 0;
    logic iq_full, dsp_valid, dsp_to_lsb, dsp_is_store, dsp_is_branch, dsp_pred_taken;
    logic [5:0] dsp_op;
    logic [4:0] dsp_rd, dsp_rs1, dsp_rs2;
    logic [31:0] dsp_imm, dsp_pc;
    int total = 0, bad = 0;
    logic [64:0] mq[$];
    logic m_valid = 0;
    fld_t m_f = '0;

    issue_unit #(.DEPTH(DEPTH), .OP_W(6)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pred_taken(if_pred),
        .iq_full(iq_full), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .dsp_valid(dsp_valid), .dsp_to_lsb(dsp_to_lsb), .dsp_is_store(dsp_is_store),
        .dsp_is_branch(dsp_is_branch), .dsp_op(dsp_op), .dsp_rd(dsp_rd), .dsp_rs1(dsp_rs1),
        .dsp_rs2(dsp_rs2), .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_pred_taken(dsp_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [31:0] i);
        return i[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic fld_t dec(input logic [64:0] e);
        fld_t f;
        logic [31:0] i;
        int f3;
        i = e[31:0];
        f3 = int'(i[14:12]);
        f = '0;
        f.pc = e[63:32];
        f.pred = e[64];
        f.rd = i[11:7];
        f.rs1 = i[19:15];
        f.imm = 32'($signed(i[31:20]));
        case (i[6:0])
            7'h37: begin f.op = 6'd1; f.rs1 = 0; f.imm = {i[31:12], 12'h0}; end
            7'h17: begin f.op = 6'd2; f.rs1 = 0; f.imm = {i[31:12], 12'h0}; end
            7'h6f: begin
                f.op = 6'd3; f.rs1 = 0; f.br = 1;
                f.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'h67: begin f.op = 6'd4; f.br = 1; end
            7'h63: begin
                f.op = 6'(8 + f3); f.br = 1; f.rd = 0; f.rs2 = i[24:20];
                f.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h03: begin f.op = 6'(16 + f3); f.lsb = 1; end
            7'h23: begin
                f.op = 6'(24 + f3); f.lsb = 1; f.st = 1; f.rd = 0; f.rs2 = i[24:20];
                f.imm = 32'($signed({i[31:25], i[11:7]}));
            end
            7'h13: f.op = 6'(32 + f3 + ((f3 == 5 && i[30]) ? 8 : 0));
            7'h33: begin f.op = 6'(48 + f3 + (i[30] ? 8 : 0)); f.rs2 = i[24:20]; f.imm = 0; end
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f, 7'h0b};
        logic [31:0] i;
        i = $urandom;
        i[6:0] = ops[$urandom_range(10)];
        return i;
    endfunction

    function automatic logic [90:0] obs();
        return {dsp_valid, iq_full, dsp_to_lsb, dsp_is_store, dsp_is_branch, dsp_op,
                dsp_rd, dsp_rs1, dsp_rs2, dsp_imm, dsp_pc, dsp_pred_taken};
    endfunction

    function automatic logic [90:0] exp_b();
        return {m_valid, mq.size() == DEPTH, m_f};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_valid = 0;
        m_f = '0;
    endfunction

    // Advance one clock: apply the queue rules to the model, then let the DUT take the edge.
    task automatic tick();
        logic [64:0] h;
        logic full;
        full = mq.size() == DEPTH;
        if (rdy) begin
            if (flush) begin
                mq.delete();
                m_valid = 0;
            end else begin
                m_valid = 0;
                if (mq.size() != 0) begin
                    h = mq[0];
                    if (!legal(h[31:0])) void'(mq.pop_front());
                    else if (!rob_full && !(dec(h).lsb ? lsb_full : rs_full)) begin
                        m_valid = 1;
                        m_f = dec(h);
                        void'(mq.pop_front());
                    end
                end
                if (if_valid && !full) mq.push_back({if_pred, if_pc, if_inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {if_valid, rob_full, rs_full, lsb_full} = '0;
        rdy = 1;
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL reset got=%h want=%h", obs(), exp_b()); end
        rst = 0;
    endtask

    task automatic test_reset_mid();
        clear();
        rob_full = 1;
        for (int k = 0; k < 5; k++) begin
            if_valid = 1; if_inst = addi(k + 1, 0, k); if_pc = 32'h100 + 4 * k;
            tick();
            total++; if (obs() !== exp_b()) begin bad++; $display("FAIL reset_mid_fill k=%0d got=%h want=%h", k, obs(), exp_b()); end
        end
        if_valid = 0;
        rst = 1;
        #2;
        model_reset();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL reset_mid_pulse got=%h want=%h", obs(), exp_b()); end
        rst = 0;
        rob_full = 0;
        if_valid = 1; if_inst = addi(2, 0, 7); if_pc = 32'h200;
        tick();
        if_valid = 0;
        tick();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL reset_mid_after got=%h want=%h", obs(), exp_b()); end
        total++; if ({dsp_valid, dsp_pc} !== {1'b1, 32'h200}) begin bad++; $display("FAIL reset_mid_first got=%b/%h want=1/00000200", dsp_valid, dsp_pc); end
    endtask

    task automatic test_addi();
        clear();
        if_valid = 1; if_inst = 32'h00500093; if_pc = 32'h400; if_pred = 0;
        tick();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL addi_edge0 got=%h want=%h", obs(), exp_b()); end
        if_valid = 0;
        tick();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL addi_edge1 got=%h want=%h", obs(), exp_b()); end
        total++;
        if ({dsp_valid, dsp_to_lsb, dsp_rd, dsp_rs1, dsp_imm} !== {1'b1, 1'b0, 5'd1, 5'd0, 32'd5}) begin
            bad++; $display("FAIL addi_fields got v=%b lsb=%b rd=%0d rs1=%0d imm=%0d want 1 0 1 0 5",
                            dsp_valid, dsp_to_lsb, dsp_rd, dsp_rs1, dsp_imm);
        end
    endtask

    task automatic test_stall();
        clear();
        lsb_full = 1;
        if_valid = 1; if_inst = 32'h0080A103; if_pc = 32'h500;
        tick();
        if_inst = 32'h002081B3; if_pc = 32'h504;
        for (int k = 0; k < 3; k++) begin
            tick();
            if_valid = 0;
            total++; if (obs() !== exp_b()) begin bad++; $display("FAIL stall_hold k=%0d got=%h want=%h", k, obs(), exp_b()); end
            total++; if (dsp_valid !== 1'b0) begin bad++; $display("FAIL stall_novalid k=%0d got=%b want=0", k, dsp_valid); end
        end
        lsb_full = 0;
        tick();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL stall_release got=%h want=%h", obs(), exp_b()); end
        total++;
        if ({dsp_valid, dsp_to_lsb, dsp_imm, dsp_pc} !== {1'b1, 1'b1, 32'd8, 32'h500}) begin
            bad++; $display("FAIL stall_lw got v=%b lsb=%b imm=%0d pc=%h want 1 1 8 500", dsp_valid, dsp_to_lsb, dsp_imm, dsp_pc);
        end
        tick();
        total++; if ({dsp_valid, dsp_to_lsb, dsp_pc} !== {1'b1, 1'b0, 32'h504}) begin bad++; $display("FAIL stall_add got v=%b lsb=%b pc=%h want 1 0 504", dsp_valid, dsp_to_lsb, dsp_pc); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] pc, next_out;
        int n_out;
        clear();
        rob_full = 1;
        pc = 32'h1000;
        for (int k = 0; k < 17; k++) begin
            if_valid = 1; if_inst = addi(k % 31 + 1, 0, k); if_pc = pc;
            if (mq.size() < DEPTH) pc += 4;
            tick();
            total++; if (obs() !== exp_b()) begin bad++; $display("FAIL fill k=%0d got=%h want=%h", k, obs(), exp_b()); end
        end
        total++; if (iq_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", iq_full); end
        rob_full = 0;
        next_out = 32'h1000;
        n_out = 0;
        for (int c = 0; c < 300 && n_out < 64; c++) begin
            if_valid = pc < 32'h1000 + 4 * 64; if_inst = addi(c % 31 + 1, 0, c); if_pc = pc;
            if (if_valid && mq.size() < DEPTH) pc += 4;
            tick();
            total++; if (obs() !== exp_b()) begin bad++; $display("FAIL wrap c=%0d got=%h want=%h", c, obs(), exp_b()); end
            if (dsp_valid === 1'b1) begin
                total++; if (dsp_pc !== next_out) begin bad++; $display("FAIL wrap_order got=%h want=%h", dsp_pc, next_out); end
                next_out += 4;
                n_out++;
            end
        end
        if_valid = 0;
        total++; if (n_out != 64) begin bad++; $display("FAIL wrap_count got=%0d want=64", n_out); end
    endtask

    task automatic test_flush();
        clear();
        rob_full = 1;
        for (int k = 0; k < 7; k++) begin
            if_valid = 1; if_inst = addi(3, 1, k); if_pc = 32'h700 + 4 * k;
            tick();
        end
        flush = 1; if_inst = addi(4, 0, 9); if_pc = 32'hBAD0;
        tick();
        total++; if (obs() !== exp_b()) begin bad++; $display("FAIL flush_edge got=%h want=%h", obs(), exp_b()); end
        flush = 0; if_valid = 0; rob_full = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (dsp_valid !== 1'b0) begin bad++; $display("FAIL flush_empty k=%0d got=%b want=0", k, dsp_valid); end
        end
        if_valid = 1; if_inst = addi(5, 0, 1); if_pc = 32'h7F0;
        tick();
        if_valid = 0;
        tick();
        total++; if ({dsp_valid, dsp_pc} !== {1'b1, 32'h7F0}) begin bad++; $display("FAIL flush_reuse got=%b/%h want=1/000007f0", dsp_valid, dsp_pc); end
    endtask

    task automatic test_bad_word();
        logic [4:0] seq;
        logic [31:0] words [3] = '{32'h00100093, 32'hFFFFFFFF, 32'h00200113};
        clear();
        seq = '0;
        for (int k = 0; k < 5; k++) begin
            if_valid = k < 3; if_inst = words[k % 3]; if_pc = 32'h900 + 4 * k;
            tick();
            seq[k] = dsp_valid;
            total++; if (obs() !== exp_b()) begin bad++; $display("FAIL bad_word k=%0d got=%h want=%h", k, obs(), exp_b()); end
        end
        total++; if (seq !== 5'b01010) begin bad++; $display("FAIL bad_word_pattern got=%b want=01010", seq); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rdy = $urandom_range(9) != 0;
            flush = $urandom_range(29) == 0;
            rob_full = $urandom_range(3) == 0;
            rs_full = $urandom_range(3) == 0;
            lsb_full = $urandom_range(3) == 0;
            if_valid = $urandom_range(9) < 7;
            if_inst = rand_inst(); if_pc = $urandom; if_pred = 1'($urandom);
            tick();
            total++; if (obs() !== exp_b()) begin bad++; $display("FAIL random c=%0d got=%h want=%h", c, obs(), exp_b()); end
        end
        rdy = 1; flush = 0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_addi();
        test_stall();
        test_fill_wrap();
        test_flush();
        test_bad_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
